mem_stage: RTL and testbench

- Memory stage of the 5-stage RV32I pipeline, directly downstream of the execute stage.
- Holds the EX/MEM pipeline register and drives the data-memory bus through a req/ack handshake with a watchdog.
- Aligns store data, extends load data, resolves the branch decision and holds the MEM/WB register.
- Stalls the upstream pipeline while a memory access is outstanding; feeds ALU_OUT_MEM and ALU_DATA_WB back to the execute-stage forwarding muxes.

---
 rtl/mem_pkg.sv | 40 ++++
 rtl/mem_stage_load_store_align.sv | 63 ++++++
 rtl/mem_stage.sv | 161 ++++++++++++++++
 tb/tb_mem_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the RV32I memory stage: funct3 codes, FSM encoding, pipeline register layouts.
package mem_pkg;
    localparam int DW = 32;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] BEQ = 3'b000;
    localparam logic [2:0] BNE = 3'b001;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic [DW-1:0] alu;
        logic [DW-1:0] sdata;
        logic [DW-1:0] pcb;
        logic          zero;
        logic [2:0]    f3;
        logic [4:0]    rd;
        logic          regwrite;
        logic          memtoreg;
        logic          memread;
        logic          memwrite;
        logic          branch;
    } exmem_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [4:0]    rd;
        logic          regwrite;
    } memwb_t;
endpackage

// File: rtl/mem_stage_load_store_align.sv
// Combinational byte-lane logic: store byte enables and lane replication, misalignment, load extraction.
// Zero latency; no flow control of its own.
module load_store_align
    import mem_pkg::*;
(
    input  logic [1:0]    addr_lo_i,
    input  logic [2:0]    funct3_i,
    input  logic          is_store_i,
    input  logic [DW-1:0] sdata_i,
    input  logic [DW-1:0] rdata_i,
    output logic [3:0]    be_o,
    output logic [DW-1:0] wdata_o,
    output logic          misalign_o,
    output logic [DW-1:0] load_o
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        be_o       = 4'hF;
        wdata_o    = sdata_i;
        misalign_o = 1'b0;
        load_o     = rdata_i;
        lane_b     = rdata_i[7:0];
        lane_h     = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        // funct3[1:0] encodes access size for both loads and stores
        case (funct3_i[1:0])
            2'b01:   misalign_o = addr_lo_i[0];
            2'b10:   misalign_o = |addr_lo_i;
            default: misalign_o = 1'b0;
        endcase

        if (is_store_i) begin
            case (funct3_i)
                SB: begin
                    be_o    = 4'b0001 << addr_lo_i;
                    wdata_o = {4{sdata_i[7:0]}};
                end
                SH: begin
                    be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                    wdata_o = {2{sdata_i[15:0]}};
                end
                default: be_o = 4'hF;
            endcase
        end

        case (addr_lo_i)
            2'd0:    lane_b = rdata_i[7:0];
            2'd1:    lane_b = rdata_i[15:8];
            2'd2:    lane_b = rdata_i[23:16];
            default: lane_b = rdata_i[31:24];
        endcase

        case (funct3_i)
            LB:      load_o = {{24{lane_b[7]}}, lane_b};
            LH:      load_o = {{16{lane_h[15]}}, lane_h};
            LBU:     load_o = {24'd0, lane_b};
            LHU:     load_o = {16'd0, lane_h};
            default: load_o = rdata_i;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: EX/MEM and MEM/WB registers, DMEM req/ack with watchdog, branch resolve.
// One cycle per instruction on zero-wait ACK; STALL_MEM holds upstream while a request waits.
module mem_stage
    import mem_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            FLUSH_MEM,
    input  logic [XLEN-1:0] ALU_OUT_EX,
    input  logic [XLEN-1:0] REG_DATA2_EX_FINAL,
    input  logic [XLEN-1:0] PC_Branch_EX,
    input  logic            ZERO_EX,
    input  logic [2:0]      FUNCT3_EX,
    input  logic [4:0]      RD_EX,
    input  logic            RegWrite_EX,
    input  logic            MemtoReg_EX,
    input  logic            MemRead_EX,
    input  logic            MemWrite_EX,
    input  logic            Branch_EX,
    input  logic            DMEM_ACK,
    input  logic [XLEN-1:0] DMEM_RDATA,
    output logic            DMEM_REQ,
    output logic            DMEM_WE,
    output logic [XLEN-1:0] DMEM_ADDR,
    output logic [XLEN-1:0] DMEM_WDATA,
    output logic [3:0]      DMEM_BE,
    output logic            STALL_MEM,
    output logic            PCSrc_MEM,
    output logic [XLEN-1:0] PC_Branch_MEM,
    output logic [XLEN-1:0] ALU_OUT_MEM,
    output logic [XLEN-1:0] ALU_DATA_WB,
    output logic [4:0]      RD_WB,
    output logic            RegWrite_WB,
    output logic            MISALIGN_MEM,
    output logic            BUS_ERR_MEM
);
    localparam int CW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

    exmem_t     exm_q, exm_d;
    memwb_t     wb_q, wb_d;
    mem_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic       done_q, done_d;

    logic          misalign;
    logic          mem_op;
    logic          req;
    logic          abort;
    logic [3:0]    be;
    logic [DW-1:0] wdata;
    logic [DW-1:0] load_ext;

    load_store_align u_align (
        .addr_lo_i  (exm_q.alu[1:0]),
        .funct3_i   (exm_q.f3),
        .is_store_i (exm_q.memwrite),
        .sdata_i    (exm_q.sdata),
        .rdata_i    (DMEM_RDATA),
        .be_o       (be),
        .wdata_o    (wdata),
        .misalign_o (misalign),
        .load_o     (load_ext)
    );

    assign mem_op = (exm_q.memread | exm_q.memwrite) & ~misalign;
    assign req    = mem_op & ~done_q;

    always_comb begin
        exm_d = exm_q;
        if (!STALL_MEM) begin
            exm_d.alu      = ALU_OUT_EX;
            exm_d.sdata    = REG_DATA2_EX_FINAL;
            exm_d.pcb      = PC_Branch_EX;
            exm_d.zero     = ZERO_EX;
            exm_d.f3       = FUNCT3_EX;
            exm_d.rd       = RD_EX;
            exm_d.regwrite = RegWrite_EX & ~FLUSH_MEM;
            exm_d.memtoreg = MemtoReg_EX & ~FLUSH_MEM;
            exm_d.memread  = MemRead_EX  & ~FLUSH_MEM;
            exm_d.memwrite = MemWrite_EX & ~FLUSH_MEM;
            exm_d.branch   = Branch_EX   & ~FLUSH_MEM;
        end
    end

    // ACK takes precedence over watchdog expiry in the same cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && !DMEM_ACK) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (!req || DMEM_ACK) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        done_d = done_q;
        if ((req && DMEM_ACK) || abort) done_d = 1'b1;
        if (!STALL_MEM)                 done_d = 1'b0;
    end

    always_comb begin
        wb_d = '0;
        if (!STALL_MEM) begin
            wb_d.data     = exm_q.memtoreg ? load_ext : exm_q.alu;
            wb_d.rd       = exm_q.rd;
            wb_d.regwrite = exm_q.regwrite & ~misalign & ~abort;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exm_q   <= '0;
            wb_q    <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            exm_q   <= exm_d;
            wb_q    <= wb_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign STALL_MEM     = req & ~DMEM_ACK & ~abort;
    assign DMEM_REQ      = req;
    assign DMEM_WE       = exm_q.memwrite & req;
    assign DMEM_ADDR     = {exm_q.alu[DW-1:2], 2'b00};
    assign DMEM_WDATA    = wdata;
    assign DMEM_BE       = be;
    assign MISALIGN_MEM  = (exm_q.memread | exm_q.memwrite) & misalign;
    assign BUS_ERR_MEM   = abort;
    assign PCSrc_MEM     = exm_q.branch & (((exm_q.f3 == BEQ) & exm_q.zero) |
                                           ((exm_q.f3 == BNE) & ~exm_q.zero));
    assign PC_Branch_MEM = exm_q.pcb;
    assign ALU_OUT_MEM   = exm_q.alu;
    assign ALU_DATA_WB   = wb_q.data;
    assign RD_WB         = wb_q.rd;
    assign RegWrite_WB   = wb_q.regwrite;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for single-cycle accesses, hand sequences for waits.
module tb_mem_stage;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        FLUSH_MEM;
    logic [31:0] ALU_OUT_EX, REG_DATA2_EX_FINAL, PC_Branch_EX;
    logic        ZERO_EX;
    logic [2:0]  FUNCT3_EX;
    logic [4:0]  RD_EX;
    logic        RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, Branch_EX;
    logic        DMEM_ACK;
    logic [31:0] DMEM_RDATA;
    logic        DMEM_REQ, DMEM_WE;
    logic [31:0] DMEM_ADDR, DMEM_WDATA;
    logic [3:0]  DMEM_BE;
    logic        STALL_MEM, PCSrc_MEM;
    logic [31:0] PC_Branch_MEM, ALU_OUT_MEM, ALU_DATA_WB;
    logic [4:0]  RD_WB;
    logic        RegWrite_WB, MISALIGN_MEM, BUS_ERR_MEM;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage #(.MAX_WAIT(16), .XLEN(32)) dut (
        .clk(clk), .reset(reset), .FLUSH_MEM(FLUSH_MEM),
        .ALU_OUT_EX(ALU_OUT_EX), .REG_DATA2_EX_FINAL(REG_DATA2_EX_FINAL),
        .PC_Branch_EX(PC_Branch_EX), .ZERO_EX(ZERO_EX), .FUNCT3_EX(FUNCT3_EX),
        .RD_EX(RD_EX), .RegWrite_EX(RegWrite_EX), .MemtoReg_EX(MemtoReg_EX),
        .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX), .Branch_EX(Branch_EX),
        .DMEM_ACK(DMEM_ACK), .DMEM_RDATA(DMEM_RDATA),
        .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
        .DMEM_WDATA(DMEM_WDATA), .DMEM_BE(DMEM_BE), .STALL_MEM(STALL_MEM),
        .PCSrc_MEM(PCSrc_MEM), .PC_Branch_MEM(PC_Branch_MEM), .ALU_OUT_MEM(ALU_OUT_MEM),
        .ALU_DATA_WB(ALU_DATA_WB), .RD_WB(RD_WB), .RegWrite_WB(RegWrite_WB),
        .MISALIGN_MEM(MISALIGN_MEM), .BUS_ERR_MEM(BUS_ERR_MEM)
    );

    typedef struct {
        logic        flush;
        logic [31:0] alu, sd, pcb;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        rw, m2r, mr, mw, br, zero, ack;
        logic [31:0] rdata;
        logic        e_req, e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_mis, e_pcsrc;
        logic [31:0] e_wbd;
        logic        e_wbrw;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic flush, logic [31:0] alu, logic [31:0] sd, logic [31:0] pcb,
                                logic [2:0] f3, logic [4:0] rd, logic rw, logic m2r, logic mr,
                                logic mw, logic br, logic zero, logic ack, logic [31:0] rdata,
                                logic e_req, logic e_we, logic [3:0] e_be, logic [31:0] e_wdata,
                                logic e_mis, logic e_pcsrc, logic [31:0] e_wbd, logic e_wbrw);
        vec_t v;
        v.flush = flush; v.alu = alu; v.sd = sd; v.pcb = pcb; v.f3 = f3; v.rd = rd;
        v.rw = rw; v.m2r = m2r; v.mr = mr; v.mw = mw; v.br = br; v.zero = zero;
        v.ack = ack; v.rdata = rdata; v.e_req = e_req; v.e_we = e_we; v.e_be = e_be;
        v.e_wdata = e_wdata; v.e_mis = e_mis; v.e_pcsrc = e_pcsrc; v.e_wbd = e_wbd;
        v.e_wbrw = e_wbrw;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bubble();
        FLUSH_MEM = 1'b0; RegWrite_EX = 1'b0; MemtoReg_EX = 1'b0;
        MemRead_EX = 1'b0; MemWrite_EX = 1'b0; Branch_EX = 1'b0;
        ALU_OUT_EX = 32'h0; REG_DATA2_EX_FINAL = 32'h0; PC_Branch_EX = 32'h0;
        ZERO_EX = 1'b0; FUNCT3_EX = 3'd0; RD_EX = 5'd0;
    endtask

    task automatic drive(input vec_t v);
        FLUSH_MEM = v.flush; ALU_OUT_EX = v.alu; REG_DATA2_EX_FINAL = v.sd;
        PC_Branch_EX = v.pcb; FUNCT3_EX = v.f3; RD_EX = v.rd; RegWrite_EX = v.rw;
        MemtoReg_EX = v.m2r; MemRead_EX = v.mr; MemWrite_EX = v.mw; Branch_EX = v.br;
        ZERO_EX = v.zero;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // load word, hold it without ACK (EX/MEM captures at the end of this task)
    task automatic issue_lw(input logic [31:0] addr, input logic [4:0] rd);
        bubble();
        ALU_OUT_EX = addr; FUNCT3_EX = LW; RD_EX = rd;
        RegWrite_EX = 1'b1; MemtoReg_EX = 1'b1; MemRead_EX = 1'b1;
        DMEM_ACK = 1'b0;
        tick();
        bubble();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [31:0] addr_snap;
        reset = 1'b1; DMEM_ACK = 1'b0; DMEM_RDATA = 32'h0;
        bubble();

        //            fl alu          sd           pcb          f3   rd  rw m2r mr mw br z ack rdata        req we be    wdata        mis pc wbd          wbrw
        vecs.push_back(mk(0, 32'h100, 32'hDEADBEEF, 32'h0,   SW,  5'd0, 0,0,0,1,0,0,1, 32'h0,        1,1,4'hF,32'hDEADBEEF,0,0,32'h100,     0));
        vecs.push_back(mk(0, 32'h102, 32'h0000ABCD, 32'h0,   SH,  5'd0, 0,0,0,1,0,0,1, 32'h0,        1,1,4'hC,32'hABCDABCD,0,0,32'h102,     0));
        vecs.push_back(mk(0, 32'h101, 32'h12345677, 32'h0,   SB,  5'd0, 0,0,0,1,0,0,1, 32'h0,        1,1,4'h2,32'h77777777,0,0,32'h101,     0));
        vecs.push_back(mk(0, 32'h103, 32'h000000AB, 32'h0,   SB,  5'd0, 0,0,0,1,0,0,1, 32'h0,        1,1,4'h8,32'hABABABAB,0,0,32'h103,     0));
        vecs.push_back(mk(0, 32'h102, 32'h0,        32'h0,   LHU, 5'd5, 1,1,1,0,0,0,1, 32'h80011234, 1,0,4'hF,32'h0,       0,0,32'h00008001,1));
        vecs.push_back(mk(0, 32'h102, 32'h0,        32'h0,   LH,  5'd6, 1,1,1,0,0,0,1, 32'h80011234, 1,0,4'hF,32'h0,       0,0,32'hFFFF8001,1));
        vecs.push_back(mk(0, 32'h204, 32'h0,        32'h0,   LW,  5'd7, 1,1,1,0,0,0,1, 32'hCAFEF00D, 1,0,4'hF,32'h0,       0,0,32'hCAFEF00D,1));
        vecs.push_back(mk(0, 32'h101, 32'h0,        32'h0,   LBU, 5'd8, 1,1,1,0,0,0,1, 32'h0000A500, 1,0,4'hF,32'h0,       0,0,32'h000000A5,1));
        vecs.push_back(mk(0, 32'h100, 32'h0,        32'h0,   LB,  5'd9, 1,1,1,0,0,0,1, 32'h0000007F, 1,0,4'hF,32'h0,       0,0,32'h0000007F,1));
        vecs.push_back(mk(0, 32'h103, 32'h0,        32'h0,   LB,  5'd9, 1,1,1,0,0,0,1, 32'h80FFFFFF, 1,0,4'hF,32'h0,       0,0,32'hFFFFFF80,1));
        vecs.push_back(mk(0, 32'h101, 32'h0,        32'h0,   LW,  5'd10,1,1,1,0,0,0,0, 32'h11112222, 0,0,4'hF,32'h0,       1,0,32'h11112222,0));
        vecs.push_back(mk(0, 32'h103, 32'h0,        32'h0,   LH,  5'd11,1,1,1,0,0,0,0, 32'h55556666, 0,0,4'hF,32'h0,       1,0,32'h00005555,0));
        vecs.push_back(mk(0, 32'h103, 32'h1,        32'h0,   SH,  5'd0, 0,0,0,1,0,0,0, 32'h0,        0,0,4'hF,32'h0,       1,0,32'h103,     0));
        vecs.push_back(mk(0, 32'h12345678,32'h0,    32'h0,   3'd0,5'd12,1,0,0,0,0,0,0, 32'h0,        0,0,4'hF,32'h0,       0,0,32'h12345678,1));
        vecs.push_back(mk(1, 32'h300, 32'h99,       32'h0,   SW,  5'd0, 0,0,0,1,0,0,0, 32'h0,        0,0,4'hF,32'h0,       0,0,32'h300,     0));
        vecs.push_back(mk(1, 32'h55,  32'h0,        32'h0,   3'd0,5'd13,1,0,0,0,0,0,0, 32'h0,        0,0,4'hF,32'h0,       0,0,32'h55,      0));
        vecs.push_back(mk(0, 32'h0,   32'h0,        32'h400, BNE, 5'd0, 0,0,0,0,1,0,0, 32'h0,        0,0,4'hF,32'h0,       0,1,32'h0,       0));
        vecs.push_back(mk(0, 32'h0,   32'h0,        32'h404, BNE, 5'd0, 0,0,0,0,1,1,0, 32'h0,        0,0,4'hF,32'h0,       0,0,32'h0,       0));
        vecs.push_back(mk(0, 32'h0,   32'h0,        32'h408, BEQ, 5'd0, 0,0,0,0,1,1,0, 32'h0,        0,0,4'hF,32'h0,       0,1,32'h0,       0));
        vecs.push_back(mk(0, 32'h0,   32'h0,        32'h40C, BEQ, 5'd0, 0,0,0,0,1,0,0, 32'h0,        0,0,4'hF,32'h0,       0,0,32'h0,       0));
        vecs.push_back(mk(0, 32'h0,   32'h0,        32'h410, 3'b100,5'd0,0,0,0,0,1,1,0, 32'h0,       0,0,4'hF,32'h0,       0,0,32'h0,       0));

        // reset state
        #12;
        chk("rst_req",   {31'd0, DMEM_REQ},    32'd0);
        chk("rst_stall", {31'd0, STALL_MEM},   32'd0);
        chk("rst_rw_wb", {31'd0, RegWrite_WB}, 32'd0);
        chk("rst_wbd",   ALU_DATA_WB,          32'd0);
        chk("rst_pcsrc", {31'd0, PCSrc_MEM},   32'd0);
        chk("rst_alu",   ALU_OUT_MEM,          32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        foreach (vecs[i]) begin
            drive(vecs[i]);
            tick();
            DMEM_ACK = vecs[i].ack; DMEM_RDATA = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_req", i),   {31'd0, DMEM_REQ},     {31'd0, vecs[i].e_req});
            chk($sformatf("v%0d_we", i),    {31'd0, DMEM_WE},      {31'd0, vecs[i].e_we});
            chk($sformatf("v%0d_mis", i),   {31'd0, MISALIGN_MEM}, {31'd0, vecs[i].e_mis});
            chk($sformatf("v%0d_pcsrc", i), {31'd0, PCSrc_MEM},    {31'd0, vecs[i].e_pcsrc});
            chk($sformatf("v%0d_stall", i), {31'd0, STALL_MEM},    32'd0);
            chk($sformatf("v%0d_aluout", i), ALU_OUT_MEM,          vecs[i].alu);
            chk($sformatf("v%0d_pcb", i),   PC_Branch_MEM,         vecs[i].pcb);
            if (vecs[i].e_req) begin
                chk($sformatf("v%0d_addr", i), DMEM_ADDR, {vecs[i].alu[31:2], 2'b00});
                chk($sformatf("v%0d_be", i),   {28'd0, DMEM_BE}, {28'd0, vecs[i].e_be});
            end
            if (vecs[i].e_we)
                chk($sformatf("v%0d_wdata", i), DMEM_WDATA, vecs[i].e_wdata);
            bubble();
            tick();
            DMEM_ACK = 1'b0;
            chk($sformatf("v%0d_wbd", i),  ALU_DATA_WB,          vecs[i].e_wbd);
            chk($sformatf("v%0d_wbrw", i), {31'd0, RegWrite_WB}, {31'd0, vecs[i].e_wbrw});
            if (vecs[i].e_wbrw)
                chk($sformatf("v%0d_rd", i), {27'd0, RD_WB}, {27'd0, vecs[i].rd});
            chk($sformatf("v%0d_mis_off", i), {31'd0, MISALIGN_MEM}, 32'd0);
        end

        // LB at 0x103, ACK on the fourth cycle; EX offers a flushed store meanwhile
        bubble();
        ALU_OUT_EX = 32'h103; FUNCT3_EX = LB; RD_EX = 5'd3;
        RegWrite_EX = 1'b1; MemtoReg_EX = 1'b1; MemRead_EX = 1'b1;
        DMEM_ACK = 1'b0;
        tick();
        ALU_OUT_EX = 32'h555; MemWrite_EX = 1'b1; FLUSH_MEM = 1'b1;
        n = 0;
        for (int k = 0; k < 3; k++) begin
            if (STALL_MEM) n++;
            chk("lb_hold_addr", DMEM_ADDR,   32'h100);
            chk("lb_hold_alu",  ALU_OUT_MEM, 32'h103);
            if (k > 0) chk("lb_wb_bubble", {31'd0, RegWrite_WB}, 32'd0);
            tick();
        end
        DMEM_ACK = 1'b1; DMEM_RDATA = 32'h80FFFFFF;
        #1;
        chk("lb_stall_cycles", n, 32'd3);
        chk("lb_stall_ack",    {31'd0, STALL_MEM}, 32'd0);
        tick();
        DMEM_ACK = 1'b0;
        chk("lb_wbd",  ALU_DATA_WB,          32'hFFFFFF80);
        chk("lb_wbrw", {31'd0, RegWrite_WB}, 32'd1);
        chk("lb_rd",   {27'd0, RD_WB},       32'd3);
        chk("lb_flushed_next", {31'd0, DMEM_REQ}, 32'd0);
        bubble();
        tick();

        // LW never acknowledged: watchdog abort
        issue_lw(32'h200, 5'd4);
        n = 0;
        while (STALL_MEM && n < 40) begin
            n++;
            tick();
        end
        chk("wd_stall_cycles", n, 32'd16);
        chk("wd_buserr",  {31'd0, BUS_ERR_MEM}, 32'd1);
        chk("wd_released", {31'd0, STALL_MEM},  32'd0);
        tick();
        chk("wd_buserr_pulse", {31'd0, BUS_ERR_MEM}, 32'd0);
        chk("wd_wbrw",         {31'd0, RegWrite_WB}, 32'd0);
        chk("wd_req_drop",     {31'd0, DMEM_REQ},    32'd0);

        // ACK arriving in the expiry cycle wins
        issue_lw(32'h208, 5'd14);
        addr_snap = DMEM_ADDR;
        for (int k = 0; k < 16; k++) tick();
        chk("race_addr_stable", DMEM_ADDR, addr_snap);
        DMEM_ACK = 1'b1; DMEM_RDATA = 32'h0BADF00D;
        #1;
        chk("race_buserr", {31'd0, BUS_ERR_MEM}, 32'd0);
        chk("race_stall",  {31'd0, STALL_MEM},   32'd0);
        tick();
        DMEM_ACK = 1'b0;
        chk("race_wbrw", {31'd0, RegWrite_WB}, 32'd1);
        chk("race_wbd",  ALU_DATA_WB,          32'h0BADF00D);

        // reset in the middle of a wait
        issue_lw(32'h20C, 5'd15);
        tick(); tick();
        chk("mid_wait_stall", {31'd0, STALL_MEM}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rstw_req",   {31'd0, DMEM_REQ},  32'd0);
        chk("rstw_stall", {31'd0, STALL_MEM}, 32'd0);
        chk("rstw_fsm",   32'(dut.state_q),   32'(IDLE));
        @(negedge clk);
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
